// File: rtl/cpu_fetch_pkg.sv
// Shared opcode, PCSource and fetch-state definitions for the CPU core front end.
package cpu_pkg;

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [1:0] PCS_NEXT   = 2'b00;
  localparam logic [1:0] PCS_REG    = 2'b01;
  localparam logic [1:0] PCS_BRANCH = 2'b11;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'd0;
  localparam fetch_state_t ST_ISSUE = 2'd1;
  localparam fetch_state_t ST_HALT  = 2'd2;

endpackage

// File: rtl/cpu_fetch_if.sv
// Fetch unit bus: instruction-memory req/valid port plus the decode/execute handshake.
interface cpu_fetch_if #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  imem_addr;
  logic             imem_req;
  logic [15:0]      imem_rdata;
  logic             imem_valid;
  logic [15:0]      instr;
  logic [3:0]       opcode;
  logic             instr_valid;
  logic [PC_W-1:0]  pc_out;
  logic [PC_W-1:0]  pc_plus2;
  logic             ex_done;
  logic [1:0]       pc_source;
  logic             branch_taken;
  logic [PC_W-1:0]  reg_target;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    output imem_addr, imem_req, instr, opcode, instr_valid, pc_out, pc_plus2, halted, retired,
    input  imem_rdata, imem_valid, ex_done, pc_source, branch_taken, reg_target
  );

  modport slave (
    input  imem_addr, imem_req, instr, opcode, instr_valid, pc_out, pc_plus2, halted, retired,
    output imem_rdata, imem_valid, ex_done, pc_source, branch_taken, reg_target
  );
endinterface

// File: rtl/cpu_next_pc.sv
// Combinational next-PC selection: sequential, register-indirect or PC-relative.
module cpu_next_pc
  import cpu_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic [8:0]      imm9,
  input  logic [1:0]      pc_source,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] reg_target,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_plus2;
  logic [PC_W-1:0] br_offset;
  logic            unused_tgt_lsb;

  assign pc_plus2       = pc + PC_W'(2);
  assign br_offset      = {{(PC_W-9){imm9[8]}}, imm9} << 1;
  assign unused_tgt_lsb = reg_target[0];

  always_comb begin
    next_pc = pc_plus2;
    if (branch_taken) begin
      case (pc_source)
        PCS_REG:    next_pc = {reg_target[PC_W-1:1], 1'b0};
        PCS_BRANCH: next_pc = pc_plus2 + br_offset;
        default:    next_pc = pc_plus2;
      endcase
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch/PC sequencer: one fetch in flight, instr_valid one cycle after imem_valid.
// Holds the issued instruction until ex_done; parks on HLT until reset.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  cpu_fetch_if.master bus
);

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:1], 1'b0};

  fetch_state_t     state;
  logic [PC_W-1:0]  pc;
  logic [15:0]      instr;
  logic [CNT_W-1:0] retired;
  logic [PC_W-1:0]  next_pc;
  logic             is_hlt;

  assign is_hlt = (instr[15:12] == OP_HLT);

  cpu_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc           (pc),
    .imm9         (instr[8:0]),
    .pc_source    (bus.pc_source),
    .branch_taken (bus.branch_taken),
    .reg_target   (bus.reg_target),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= RESET_PC_ALIGNED;
      instr   <= '0;
      retired <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.imem_valid) begin
            instr <= bus.imem_rdata;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // HLT retires on its own; execute's ex_done is not awaited for it
          if (is_hlt) begin
            state   <= ST_HALT;
            retired <= retired + CNT_W'(1);
          end else if (bus.ex_done) begin
            pc      <= next_pc;
            retired <= retired + CNT_W'(1);
            state   <= ST_FETCH;
          end
        end
        ST_HALT:  state <= ST_HALT;
        default:  state <= ST_FETCH;
      endcase
    end
  end

  assign bus.imem_req    = (state == ST_FETCH) && !rst;
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr;
  assign bus.opcode      = instr[15:12];
  assign bus.instr_valid = (state == ST_ISSUE);
  assign bus.pc_out      = pc;
  assign bus.pc_plus2    = pc + PC_W'(2);
  assign bus.halted      = (state == ST_HALT);
  assign bus.retired     = retired;

endmodule

// File: tb/tb_cpu_fetch.sv
// Randomized bench for cpu_fetch against an arithmetic next-PC / retire-count model.
module tb_cpu_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_fetch_if #(.PC_W(16), .CNT_W(16)) bus ();

  cpu_fetch #(.PC_W(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] m_pc;
  logic [15:0] m_ret;

  function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] w,
                                             input logic [1:0] src, input logic taken,
                                             input logic [15:0] tgt);
    int off;
    off = int'(w[8:0]);
    if (off >= 256) off = off - 512;
    if (taken && src == 2'b01) return tgt & 16'hFFFE;
    if (taken && src == 2'b11) return 16'(int'(pc) + 2 + 2 * off);
    return 16'(int'(pc) + 2);
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF) w[15:12] = 4'h0;
    return w;
  endfunction

  // Leaves the bench at the negedge after ex_done (or in ISSUE for HLT).
  task automatic fetch_issue(input logic [15:0] word, input int lat, input logic [1:0] src,
                             input logic taken, input logic [15:0] tgt);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: imem_req=%b required 1", bus.imem_req);
    end
    for (int i = 0; i <= lat; i++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold: req=%b addr=%h valid=%b required req=1 addr=%h valid=0",
                 bus.imem_req, bus.imem_addr, bus.instr_valid, m_pc);
      end
      if (i < lat) begin
        bus.imem_rdata = 16'($urandom);
        @(negedge clk);
      end
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 16'($urandom);
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== word || bus.opcode !== word[15:12] ||
        bus.pc_out !== m_pc || bus.pc_plus2 !== 16'(m_pc + 16'd2) || bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL issue: valid=%b instr=%h op=%h pc=%h pc2=%h req=%b required 1 %h %h %h %h 0",
               bus.instr_valid, bus.instr, bus.opcode, bus.pc_out, bus.pc_plus2, bus.imem_req,
               word, word[15:12], m_pc, 16'(m_pc + 16'd2));
    end
    if (word[15:12] == 4'hF) return;
    repeat ($urandom_range(0, 3)) begin
      bus.pc_source    = 2'($urandom);
      bus.branch_taken = 1'($urandom);
      bus.reg_target   = 16'($urandom);
      bus.imem_valid   = 1'($urandom);
      @(negedge clk);
      bus.imem_valid = 1'b0;
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== word || bus.pc_out !== m_pc) begin
        errors++;
        $display("FAIL issue_hold: valid=%b instr=%h pc=%h required 1 %h %h",
                 bus.instr_valid, bus.instr, bus.pc_out, word, m_pc);
      end
    end
    bus.ex_done      = 1'b1;
    bus.pc_source    = src;
    bus.branch_taken = taken;
    bus.reg_target   = tgt;
    @(negedge clk);
    bus.ex_done = 1'b0;
    m_pc  = model_next(m_pc, word, src, taken, tgt);
    m_ret = m_ret + 16'd1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc ||
        bus.retired !== m_ret) begin
      errors++;
      $display("FAIL retire: valid=%b req=%b addr=%h retired=%0d required 0 1 %h %0d",
               bus.instr_valid, bus.imem_req, bus.imem_addr, bus.retired, m_pc, m_ret);
    end
  endtask

  task automatic goto_pc(input logic [15:0] t);
    fetch_issue(rand_word(), $urandom_range(0, 2), 2'b01, 1'b1, t);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.halted !== 1'b0 ||
        bus.retired !== 16'd0 || bus.instr !== 16'd0 || bus.pc_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b halted=%b retired=%0d instr=%h pc=%h required all zero",
               bus.imem_req, bus.instr_valid, bus.halted, bus.retired, bus.instr, bus.pc_out);
    end
    rst = 1'b0;
    m_pc = 16'h0000;
    m_ret = 16'd0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL first_fetch: req=%b addr=%h required 1 0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_basic();
    fetch_issue(16'h0123, 2, 2'b00, 1'b0, 16'h0000);
    checks++;
    if (bus.imem_addr !== 16'h0002 || bus.retired !== 16'd1) begin
      errors++;
      $display("FAIL basic_next: addr=%h retired=%0d required 0002 1", bus.imem_addr, bus.retired);
    end
  endtask

  task automatic test_branch();
    goto_pc(16'h0010);
    fetch_issue(16'hC1FE, 1, 2'b11, 1'b1, 16'hAAAA);
    checks++;
    if (bus.imem_addr !== 16'h000E) begin
      errors++;
      $display("FAIL b_taken: addr=%h required 000E", bus.imem_addr);
    end
    goto_pc(16'h0010);
    fetch_issue(16'hC1FE, 0, 2'b11, 1'b0, 16'hAAAA);
    checks++;
    if (bus.imem_addr !== 16'h0012) begin
      errors++;
      $display("FAIL b_not_taken: addr=%h required 0012", bus.imem_addr);
    end
    goto_pc(16'h0020);
    fetch_issue(16'hD000, 1, 2'b01, 1'b1, 16'h1235);
    checks++;
    if (bus.imem_addr !== 16'h1234) begin
      errors++;
      $display("FAIL br_taken: addr=%h required 1234", bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    goto_pc(16'hFFFE);
    fetch_issue(16'h0042, 1, 2'b00, 1'b1, 16'h5555);
    checks++;
    if (bus.imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_seq: addr=%h required 0000", bus.imem_addr);
    end
    goto_pc(16'hFFFC);
    fetch_issue(16'hC003, 0, 2'b11, 1'b1, 16'h5555);
    checks++;
    if (bus.imem_addr !== 16'h0004) begin
      errors++;
      $display("FAIL wrap_branch: addr=%h required 0004", bus.imem_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      fetch_issue(rand_word(), $urandom_range(0, 4), 2'($urandom), 1'($urandom), 16'($urandom));
    end
  endtask

  task automatic test_halt();
    goto_pc(16'h0040);
    fetch_issue(16'hF000, 1, 2'b00, 1'b0, 16'h0000);
    bus.ex_done      = 1'b1;
    bus.pc_source    = 2'b01;
    bus.branch_taken = 1'b1;
    bus.reg_target   = 16'h1000;
    @(negedge clk);
    m_ret = m_ret + 16'd1;
    checks++;
    if (bus.halted !== 1'b1 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 ||
        bus.pc_out !== 16'h0040 || bus.retired !== m_ret) begin
      errors++;
      $display("FAIL halt_entry: halted=%b valid=%b req=%b pc=%h retired=%0d required 1 0 0 0040 %0d",
               bus.halted, bus.instr_valid, bus.imem_req, bus.pc_out, bus.retired, m_ret);
    end
    for (int i = 0; i < 20; i++) begin
      bus.ex_done    = 1'($urandom);
      bus.imem_valid = 1'($urandom);
      bus.imem_rdata = 16'($urandom);
      @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
          bus.pc_out !== 16'h0040 || bus.retired !== m_ret) begin
        errors++;
        $display("FAIL halt_park: halted=%b req=%b valid=%b pc=%h retired=%0d required 1 0 0 0040 %0d",
                 bus.halted, bus.imem_req, bus.instr_valid, bus.pc_out, bus.retired, m_ret);
      end
    end
    bus.ex_done    = 1'b0;
    bus.imem_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc = 16'h0000;
    m_ret = 16'd0;
    @(negedge clk);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 16'h1234;
    rst = 1'b1;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    checks++;
    if (bus.instr !== 16'h0000 || bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b0 ||
        bus.halted !== 1'b0 || bus.retired !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_fetch: instr=%h valid=%b req=%b halted=%b retired=%0d required 0000 0 0 0 0",
               bus.instr, bus.instr_valid, bus.imem_req, bus.halted, bus.retired);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: req=%b addr=%h valid=%b required 1 0000 0",
               bus.imem_req, bus.imem_addr, bus.instr_valid);
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 16'h2222;
    @(negedge clk);
    bus.imem_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr !== 16'h0000 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_issue: instr=%h valid=%b required 0000 0", bus.instr, bus.instr_valid);
    end
    rst = 1'b0;
    fetch_issue(16'h0777, 1, 2'b00, 1'b0, 16'h0000);
    fetch_issue(rand_word(), 2, 2'b11, 1'b1, 16'h0000);
  endtask

  initial begin
    bus.imem_valid   = 1'b0;
    bus.imem_rdata   = 16'h0000;
    bus.ex_done      = 1'b0;
    bus.pc_source    = 2'b00;
    bus.branch_taken = 1'b0;
    bus.reg_target   = 16'h0000;
    m_pc  = 16'h0000;
    m_ret = 16'd0;
    test_reset();
    test_basic();
    test_branch();
    test_wrap();
    test_random();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
